// File: rtl/seg7_scan.sv
// Multi-digit seven-segment scanner: latches an N-digit hex value and drives a
// time-multiplexed scan bus plus a parallel per-digit bus, with lz/blink/enable blanking.

module seg7_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       en,
  input  logic       blink,
  input  logic       ph,
  input  logic       lzs,
  output logic [7:0] glyph
);
  logic [6:0] dec;
  logic       blank;

  always_comb begin
    dec = 7'h7f;
    case (nib)
      4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'ha: dec = 7'h08;  4'hb: dec = 7'h03;
      4'hc: dec = 7'h46;  4'hd: dec = 7'h21;  4'he: dec = 7'h06;  4'hf: dec = 7'h0e;
      default: dec = 7'h7f;
    endcase
  end

  // lz suppression kills only the glyph; the dp stays visible
  assign blank = !en || (blink && ph);
  assign glyph = {blank ? 1'b1 : ~dp, (blank || lzs) ? 7'h7f : dec};
endmodule

module seg7_scan #(
  parameter int NDIGITS      = 8,
  parameter int DIV          = 1000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     en_mask,
  input  logic [NDIGITS-1:0]     blink_mask,
  input  logic                   lz_en,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp_n,
  output logic [8*NDIGITS-1:0]   seg_all,
  output logic                   frame_done
);
  localparam int DW = $clog2(DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0]          div_q, div_nx;
  logic [IW-1:0]          idx_q, idx_nx;
  logic [BW-1:0]          bcnt_q, bcnt_nx;
  logic                   ph_q, ph_nx;
  logic [4*NDIGITS-1:0]   pend_val, act_val, act_val_nx;
  logic [NDIGITS-1:0]     pend_dp, act_dp, act_dp_nx;
  logic                   tick, fend;
  logic [NDIGITS:0]       zab;
  logic [NDIGITS-1:0]     lzs;
  logic [NDIGITS-1:0][7:0] lane_glyph;

  assign tick = (div_q == DW'(DIV - 1));
  assign fend = tick && (idx_q == IW'(NDIGITS - 1));

  always_comb begin
    div_nx     = tick ? '0 : div_q + 1'b1;
    idx_nx     = idx_q;
    bcnt_nx    = bcnt_q;
    ph_nx      = ph_q;
    act_val_nx = act_val;
    act_dp_nx  = act_dp;
    if (tick) idx_nx = fend ? '0 : idx_q + 1'b1;
    if (fend) begin
      act_val_nx = load ? value : pend_val;
      act_dp_nx  = load ? dp_in : pend_dp;
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_nx = '0;
        ph_nx   = ~ph_q;
      end else begin
        bcnt_nx = bcnt_q + 1'b1;
      end
    end
  end

  // outputs are built from next-state so they line up with the counters
  assign zab[NDIGITS] = 1'b1;
  genvar i;
  generate
    for (i = 0; i < NDIGITS; i++) begin : g_lane
      assign zab[i] = zab[i+1] && (act_val_nx[4*i +: 4] == 4'h0);
      assign lzs[i] = (i != 0) && lz_en && zab[i];
      seg7_lane u_lane (
        .nib   (act_val_nx[4*i +: 4]),
        .dp    (act_dp_nx[i]),
        .en    (en_mask[i]),
        .blink (blink_mask[i]),
        .ph    (ph_nx),
        .lzs   (lzs[i]),
        .glyph (lane_glyph[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      ph_q       <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      an         <= '1;
      seg        <= 7'h7f;
      dp_n       <= 1'b1;
      seg_all    <= '1;
      frame_done <= 1'b0;
    end else begin
      div_q      <= div_nx;
      idx_q      <= idx_nx;
      bcnt_q     <= bcnt_nx;
      ph_q       <= ph_nx;
      act_val    <= act_val_nx;
      act_dp     <= act_dp_nx;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      an         <= (div_nx < DW'(BLANK)) ? '1 : ~(NDIGITS'(1) << idx_nx);
      seg        <= lane_glyph[idx_nx][6:0];
      dp_n       <= lane_glyph[idx_nx][7];
      seg_all    <= lane_glyph;
      frame_done <= fend;
    end
  end
endmodule
